// File: rtl/seq_pkg.sv
// Shared encodings for the phase sequencer and the arbiter FSM.
package seq_pkg;

  typedef enum logic [1:0] {
    FIRST  = 2'b11,
    SECOND = 2'b01,
    THIRD  = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2
  } ctrl_t;

endpackage

// File: rtl/phase_seq.sv
// Three-phase sequencer FIRST->SECOND->THIRD with pause and restart.
module phase_seq
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause,
  input  logic       restart,
  output logic [1:0] phase,
  output logic       odd,
  output logic       even,
  output logic       terminal
);

  phase_t ph, ph_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= FIRST;
    else        ph <= ph_n;
  end

  always_comb begin
    ph_n = ph;
    if (restart) begin
      ph_n = FIRST;
    end else if (!pause) begin
      unique case (ph)
        FIRST:   ph_n = SECOND;
        SECOND:  ph_n = THIRD;
        THIRD:   ph_n = FIRST;
        default: ph_n = FIRST;
      endcase
    end
  end

  assign phase    = ph;
  assign odd      = (ph != SECOND);
  assign even     = (ph == SECOND);
  assign terminal = (ph == THIRD) && !pause;

endmodule

// File: rtl/seq_arbiter.sv
// Round-robin owner selection in front of one shared phase_seq;
// each grant runs a requested number of full sequences.
module seq_arbiter
  import seq_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         hold,
  input  logic [CNT_W-1:0]         len,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic [1:0]               phase,
  output logic                     odd,
  output logic                     even,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id
);

  localparam int IW = $clog2(N_REQ);

  ctrl_t          state, state_n;
  logic [IW-1:0]  ptr, owner, pick, cand, owner_inc;
  logic [CNT_W-1:0] remaining;
  logic           found;
  logic           pause, restart, terminal;
  logic           take, abort, finish, dec;
  logic           own_req, own_hold;

  phase_seq u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .pause    (pause),
    .restart  (restart),
    .phase    (phase),
    .odd      (odd),
    .even     (even),
    .terminal (terminal)
  );

  assign own_req   = req[owner];
  assign own_hold  = hold[owner];
  assign owner_inc = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign busy      = (state != IDLE);

  // First requester at or after ptr in cyclic order.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    pause   = 1'b1;
    restart = 1'b1;
    take    = 1'b0;
    abort   = 1'b0;
    finish  = 1'b0;
    dec     = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          take    = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        restart = 1'b0;
        if (!own_req) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = RUN;
        end
      end
      RUN: begin
        restart = 1'b0;
        pause   = own_hold;
        if (!own_req) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (terminal) begin
          if (remaining <= CNT_W'(1)) begin
            finish  = 1'b1;
            state_n = IDLE;
          end else begin
            dec = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      owner     <= '0;
      remaining <= '0;
      gnt       <= '0;
      done      <= 1'b0;
      done_id   <= '0;
    end else begin
      done <= 1'b0;
      if (take) begin
        owner     <= pick;
        remaining <= (len == '0) ? CNT_W'(1) : len;
        gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
      end
      if (abort || finish) begin
        gnt <= '0;
        ptr <= owner_inc;
      end
      if (finish) begin
        done    <= 1'b1;
        done_id <= owner;
      end
      if (dec) remaining <= remaining - 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_arbiter.sv
// Vector table, directed corner sequences and randomized run
// against a transaction-level reference model.
module tb_seq_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, hold, len;
  logic [3:0] gnt;
  logic       busy, odd, even, done;
  logic [1:0] phase, done_id;

  int tests = 0;
  int fails = 0;

  seq_arbiter #(.N_REQ(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .hold(hold), .len(len),
    .gnt(gnt), .busy(busy), .phase(phase), .odd(odd), .even(even),
    .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; hold = '0; len = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] r, h, l;
    logic [3:0] g;
    logic [1:0] ph;
    logic       b, d;
    logic [1:0] id;
  } vec_t;

  vec_t tbl[15];

  // Reference model: ownership + position within the 3-phase sequence.
  int m_busy, m_first, m_owner, m_left, m_pidx, m_ptr, m_done, m_id;
  logic [1:0] pcode[3];

  task automatic m_reset();
    m_busy = 0; m_first = 0; m_owner = 0; m_left = 0;
    m_pidx = 0; m_ptr = 0; m_done = 0; m_id = 0;
  endtask

  task automatic m_step(input logic [3:0] r, h, l);
    m_done = 0;
    if (m_busy == 0) begin
      m_pidx = 0;
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (m_ptr + i) % 4;
        if (m_busy == 0 && r[c]) begin
          m_busy = 1; m_first = 1; m_owner = c;
          m_left = (l == 0) ? 1 : int'(l);
        end
      end
    end else if (!r[m_owner]) begin
      if (m_first == 0 && !h[m_owner]) m_pidx = (m_pidx + 1) % 3;
      m_busy = 0;
      m_ptr = (m_owner + 1) % 4;
    end else if (m_first != 0) begin
      m_first = 0;
    end else if (!h[m_owner]) begin
      if (m_pidx == 2) begin
        m_pidx = 0;
        if (m_left == 1) begin
          m_busy = 0; m_done = 1; m_id = m_owner;
          m_ptr = (m_owner + 1) % 4;
        end else begin
          m_left--;
        end
      end else begin
        m_pidx++;
      end
    end
  endtask

  function automatic logic [11:0] m_exp();
    logic [3:0] g;
    g = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
    return {g, m_busy[0], pcode[m_pidx], m_pidx != 1, m_pidx == 1,
            m_done[0], 2'(m_id)};
  endfunction

  logic [3:0] rq;
  int n;

  initial begin
    pcode[0] = 2'b11; pcode[1] = 2'b01; pcode[2] = 2'b10;

    // r, h, l, gnt, phase, busy, done, done_id
    tbl[0]  = '{4'b0010, 4'h0, 4'd2, 4'b0010, 2'b11, 1, 0, 0};
    tbl[1]  = '{4'b0010, 4'h0, 4'd0, 4'b0010, 2'b11, 1, 0, 0};
    tbl[2]  = '{4'b0010, 4'h0, 4'd0, 4'b0010, 2'b01, 1, 0, 0};
    tbl[3]  = '{4'b0010, 4'h0, 4'd0, 4'b0010, 2'b10, 1, 0, 0};
    tbl[4]  = '{4'b0010, 4'h0, 4'd0, 4'b0010, 2'b11, 1, 0, 0};
    tbl[5]  = '{4'b0010, 4'h0, 4'd0, 4'b0010, 2'b01, 1, 0, 0};
    tbl[6]  = '{4'b0010, 4'h0, 4'd0, 4'b0010, 2'b10, 1, 0, 0};
    tbl[7]  = '{4'b0010, 4'h0, 4'd0, 4'b0000, 2'b11, 0, 1, 1};
    tbl[8]  = '{4'b0000, 4'h0, 4'd0, 4'b0000, 2'b11, 0, 0, 1};
    tbl[9]  = '{4'b0100, 4'h0, 4'd0, 4'b0100, 2'b11, 1, 0, 1};
    tbl[10] = '{4'b0100, 4'h0, 4'd0, 4'b0100, 2'b11, 1, 0, 1};
    tbl[11] = '{4'b0100, 4'h0, 4'd0, 4'b0100, 2'b01, 1, 0, 1};
    tbl[12] = '{4'b0100, 4'h0, 4'd0, 4'b0100, 2'b10, 1, 0, 1};
    tbl[13] = '{4'b0100, 4'h0, 4'd0, 4'b0000, 2'b11, 0, 1, 2};
    tbl[14] = '{4'b0000, 4'h0, 4'd0, 4'b0000, 2'b11, 0, 0, 2};

    do_reset();
    check("reset", {gnt, busy, phase, odd, even, done, done_id},
          {4'b0000, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00});

    foreach (tbl[k]) begin
      req = tbl[k].r; hold = tbl[k].h; len = tbl[k].l;
      step();
      check($sformatf("vec%0d", k), {gnt, phase, busy, done, done_id},
            {tbl[k].g, tbl[k].ph, tbl[k].b, tbl[k].d, tbl[k].id});
    end

    // Round-robin with all requesting, len=1.
    do_reset();
    req = 4'b1111; len = 4'd1;
    for (int k = 0; k < 25; k++) begin
      logic [3:0] eg;
      step();
      eg = ((k % 5) < 4) ? (4'b0001 << ((k / 5) % 4)) : 4'b0000;
      check($sformatf("rr%0d", k), gnt, eg);
    end

    // Hold in THIRD delays done by 3 cycles.
    do_reset();
    req = 4'b0100; len = 4'd1;
    repeat (4) step();
    check("hold_pre", phase, 2'b10);
    hold = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("hold_ph%0d", k), {phase, done}, {2'b10, 1'b0});
    end
    hold = '0;
    step();
    check("hold_done", {done, done_id, gnt}, {1'b1, 2'd2, 4'b0000});

    // Abort in SECOND, then pointer moves to requester 1.
    do_reset();
    req = 4'b0001; len = 4'd2;
    repeat (3) step();
    check("ab_second", phase, 2'b01);
    req = 4'b0000;
    step();
    check("ab_idle", {gnt, busy, done}, {4'b0000, 1'b0, 1'b0});
    req = 4'b0011;
    step();
    check("ab_first", {phase, done}, {2'b11, 1'b0});
    check("ab_next", gnt, 4'b0010);

    // Asynchronous reset mid-RUN.
    do_reset();
    req = 4'b0100; len = 4'd3;
    repeat (3) step();
    check("rst_pre", phase, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {gnt, busy, phase, done}, {4'b0000, 1'b0, 2'b11, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111; len = 4'd1;
    step();
    check("rst_regrant", gnt, 4'b0001);

    // Randomized run against the reference model.
    do_reset();
    m_reset();
    rq = '0;
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (!rq[b]) rq[b] = ($urandom_range(3) == 0);
        else if ($urandom_range(24) == 0) rq[b] = 1'b0;
      end
      req  = rq;
      hold = 4'($urandom_range(15)) & 4'($urandom_range(15));
      len  = 4'($urandom_range(3));
      m_step(req, hold, len);
      step();
      if (m_done != 0) begin
        rq[m_id] = 1'b0;
        n++;
      end
      check($sformatf("rand%0d", k),
            {gnt, busy, phase, odd, even, done, done_id}, m_exp());
    end
    check("rand_done_seen", 32'(n > 20), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
